// File: rtl/counter_period_monitor.sv
// Watches the two-phase x/y counter, measures each period (peak x, peak y, protocol
// errors) and queues one record per period in a small FIFO for the readback stage.
module counter_period_monitor #(
    parameter int W     = 8,
    parameter int IDX_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                   _i_clk,
    input  logic                   _i_rst,
    input  logic [W-1:0]           _i_x,
    input  logic [W-1:0]           _i_y,
    input  logic                   _i_ready,
    output logic [IDX_W+2*W+1:0]   __output
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = 1 + IDX_W + 2*W;
    localparam logic [W-1:0] ONE_W = W'(1);

    typedef enum logic [1:0] {IDLE, RUN_X, RUN_Y, RESYNC} state_t;

    state_t           state;
    logic [W-1:0]     px, py;
    logic [W-1:0]     x_peak, y_peak;
    logic             err_pend, ovf_pend;
    logic [IDX_W-1:0] index;

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    logic             sample_zero, x_inc, x_hold, y_inc;
    logic             fifo_empty, fifo_full;
    logic             pop, push_req, push_ok;
    logic [REC_W-1:0] record;

    // Handshake: a record is offered while valid (FIFO not empty); it is consumed on
    // a cycle with valid & _i_ready, and the head holds still otherwise.
    assign sample_zero = (_i_x == '0) && (_i_y == '0);
    assign x_inc       = (_i_x == px + ONE_W);
    assign x_hold      = (_i_x == px);
    assign y_inc       = (_i_y == py + ONE_W);

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CW'(DEPTH));
    assign pop         = !fifo_empty && _i_ready;

    // Every state except IDLE ends its period on the (0,0) sample.
    assign push_req    = (state != IDLE) && sample_zero;
    assign push_ok     = push_req && (!fifo_full || pop);
    assign record      = {err_pend | ovf_pend, index, x_peak, y_peak};

    assign __output    = fifo_empty ? '0 : {1'b1, mem[rd_ptr]};

    always_ff @(posedge _i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= record;
        end
    end

    always_ff @(posedge _i_clk or posedge _i_rst) begin
        if (_i_rst) begin
            state    <= IDLE;
            px       <= '0;
            py       <= '0;
            x_peak   <= '0;
            y_peak   <= '0;
            err_pend <= 1'b0;
            ovf_pend <= 1'b0;
            index    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            px <= _i_x;
            py <= _i_y;

            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A dropped record still consumes an index and taints the next one.
            if (push_req) begin
                index <= index + IDX_W'(1);
                if (push_ok) begin
                    err_pend <= 1'b0;
                    ovf_pend <= 1'b0;
                end else begin
                    ovf_pend <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (sample_zero) begin
                        state <= IDLE;
                    end else if (_i_x == ONE_W && _i_y == '0) begin
                        state  <= RUN_X;
                        x_peak <= ONE_W;
                        y_peak <= '0;
                    end else begin
                        state    <= RESYNC;
                        err_pend <= 1'b1;
                        x_peak   <= '0;
                        y_peak   <= '0;
                    end
                end
                RUN_X: begin
                    if (sample_zero) begin
                        state <= IDLE;
                    end else if (x_inc && _i_y == '0) begin
                        x_peak <= _i_x;
                    end else if (x_hold && _i_y == ONE_W) begin
                        state  <= RUN_Y;
                        y_peak <= ONE_W;
                    end else begin
                        state    <= RESYNC;
                        err_pend <= 1'b1;
                    end
                end
                RUN_Y: begin
                    if (sample_zero) begin
                        state <= IDLE;
                    end else if (x_hold && y_inc) begin
                        y_peak <= _i_y;
                    end else begin
                        state    <= RESYNC;
                        err_pend <= 1'b1;
                    end
                end
                RESYNC: begin
                    if (sample_zero) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
